// File: rtl/my_ram8.sv
// my_ram8: eight-word by 16-bit register file with address-decoded write
// strobes and a combinational 8:1 read mux.
`default_nettype none

module my_ram8 (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] out,
  input  logic [15:0] in,
  input  logic        load,
  input  logic [2:0]  address
);

  localparam int unsigned DEPTH = 8;
  localparam int unsigned WIDTH = 16;

  logic [WIDTH-1:0] word_q [DEPTH];
  logic [DEPTH-1:0] load_dec;

  // One-hot demux of the write strobe; every other word holds.
  always_comb begin
    load_dec          = '0;
    load_dec[address] = load;
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_word
      logic [WIDTH-1:0] word_d;

      always_comb begin
        word_d = word_q[gi];
        if (load_dec[gi]) begin
          word_d = in;
        end
      end

      // Reset wins over a write presented on the same edge.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          word_q[gi] <= '0;
        end else begin
          word_q[gi] <= word_d;
        end
      end
    end
  endgenerate

  assign out = word_q[address];

endmodule

`default_nettype wire

// File: tb/tb_my_ram8.sv
// tb_my_ram8: self-checking bench for my_ram8 against an array model of the
// eight stored words, using directed scenarios and $urandom traffic.
`default_nettype none

module tb_my_ram8;

  logic        clk;
  logic        rst_n;
  logic [15:0] out;
  logic [15:0] in;
  logic        load;
  logic [2:0]  address;

  logic [15:0] mem [8];
  int          n_tests;
  int          n_fail;

  my_ram8 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .out     (out),
    .in      (in),
    .load    (load),
    .address (address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and update the model with the edge's effect.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    end else if (load) begin
      mem[address] = in;
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; load = 1'b1; in = 16'hFFFF; address = 3'd0;
    tick();
    address = 3'd5;
    tick();
    rst_n = 1'b1; load = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address = a[2:0];
      #1;
      n_tests++;
      if (out !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_clear addr=%0d got=%h exp=0000", a, out);
      end
    end
  endtask

  task automatic test_write_all();
    logic [15:0] exp;
    for (int a = 0; a < 8; a++) begin
      address = a[2:0]; in = 16'(16'h1111 * a); load = 1'b1;
      tick();
    end
    load = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address = a[2:0];
      exp = 16'(16'h1111 * a);
      #1;
      n_tests++;
      if (out !== exp || out !== mem[a]) begin
        n_fail++;
        $display("FAIL write_all addr=%0d got=%h exp=%h", a, out, exp);
      end
    end
  endtask

  task automatic test_isolation();
    address = 3'd5; in = 16'hA5A5; load = 1'b1;
    tick();
    load = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address = a[2:0];
      #1;
      n_tests++;
      if (out !== mem[a] || (a == 5 && out !== 16'hA5A5)) begin
        n_fail++;
        $display("FAIL isolation addr=%0d got=%h exp=%h", a, out, mem[a]);
      end
    end
  endtask

  task automatic test_read_during_write();
    address = 3'd3; in = 16'hBEEF; load = 1'b1;
    #1;
    n_tests++;
    if (out !== 16'h3333) begin
      n_fail++;
      $display("FAIL rdw_before got=%h exp=3333", out);
    end
    tick();
    n_tests++;
    if (out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rdw_after got=%h exp=beef", out);
    end
    load = 1'b0; in = 16'h0000;
    tick();
    n_tests++;
    if (out !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL rdw_hold got=%h exp=beef", out);
    end
  endtask

  task automatic test_reset_priority();
    logic [15:0] d;
    for (int a = 0; a < 8; a++) begin
      address = a[2:0]; in = 16'($urandom_range(1, 16'hFFFF)); load = 1'b1;
      tick();
    end
    rst_n = 1'b0; load = 1'b1; address = 3'd2; in = 16'h1234;
    tick();
    rst_n = 1'b1; load = 1'b0;
    for (int a = 0; a < 8; a++) begin
      address = a[2:0];
      #1;
      n_tests++;
      if (out !== 16'h0000) begin
        n_fail++;
        $display("FAIL reset_priority addr=%0d got=%h exp=0000", a, out);
      end
    end
    // Reset on one edge, write on the very next edge.
    rst_n = 1'b0;
    tick();
    d = 16'($urandom);
    rst_n = 1'b1; load = 1'b1; address = 3'd6; in = d;
    tick();
    load = 1'b0;
    #1;
    n_tests++;
    if (out !== d) begin
      n_fail++;
      $display("FAIL reset_exit_write got=%h exp=%h", out, d);
    end
    address = 3'd1;
    #1;
    n_tests++;
    if (out !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_exit_other got=%h exp=0000", out);
    end
  endtask

  task automatic test_load_low_hold();
    for (int a = 0; a < 8; a++) begin
      address = a[2:0]; in = 16'($urandom); load = 1'b1;
      tick();
    end
    load = 1'b0;
    for (int k = 0; k < 20; k++) begin
      address = 3'($urandom); in = 16'($urandom);
      tick();
      n_tests++;
      if (out !== mem[address]) begin
        n_fail++;
        $display("FAIL hold addr=%0d got=%h exp=%h", address, out, mem[address]);
      end
    end
    for (int a = 0; a < 8; a++) begin
      address = a[2:0];
      #1;
      n_tests++;
      if (out !== mem[a]) begin
        n_fail++;
        $display("FAIL hold_sweep addr=%0d got=%h exp=%h", a, out, mem[a]);
      end
    end
  endtask

  task automatic test_back_to_back();
    // Random mix of writes and reads; out checked before every edge.
    for (int k = 0; k < 60; k++) begin
      address = 3'($urandom); in = 16'($urandom); load = 1'($urandom);
      #1;
      n_tests++;
      if (out !== mem[address]) begin
        n_fail++;
        $display("FAIL b2b step=%0d addr=%0d got=%h exp=%h", k, address, out, mem[address]);
      end
      tick();
    end
    // Same address twice in a row: the second write wins.
    address = 3'd4; in = 16'h1357; load = 1'b1;
    tick();
    in = 16'h2468;
    tick();
    load = 1'b0;
    #1;
    n_tests++;
    if (out !== 16'h2468) begin
      n_fail++;
      $display("FAIL same_addr_last_wins got=%h exp=2468", out);
    end
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst_n = 1'b0; load = 1'b0; in = '0; address = '0;
    for (int i = 0; i < 8; i++) mem[i] = 16'h0000;
    test_reset();
    test_write_all();
    test_isolation();
    test_read_during_write();
    test_reset_priority();
    test_load_low_hold();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
